// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencing unit:
// parameter defaults, next-PC source enum and width helper.
package pc_pkg;

  localparam int XLEN_D = 32;
  localparam int STEP_D = 4;
  localparam int RESET_PC_D = 0;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_REDIR,
    NPC_RAS
  } npc_src_e;

  // Never returns 0 so one-entry selects still get a real bit
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count.
// Pushing when full silently overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = clog2_safe(RAS_DEPTH);
  localparam int CW = clog2_safe(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(RAS_DEPTH));
  assign top   = mem[ptr];

  // ptr indexes the current top; the slot above it is the oldest when full
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= din;
    end else if (push) begin
      mem[ptr + AW'(1)] <= din;
      ptr <= ptr + AW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - AW'(1);
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with redirect sources and return-address stack.
// Priority: RAS pop, then redirect, then sequential step.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NSRC = 4,
  parameter int STEP = STEP_D,
  parameter int RESET_PC = RESET_PC_D,
  parameter int RAS_DEPTH = 4,
  localparam int SW = clog2_safe(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 redirect,
  input  logic [SW-1:0]        sel,
  input  logic [NSRC*XLEN-1:0] src_din,
  input  logic                 call,
  input  logic                 ret,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_next,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ret_underflow,
  output logic                 sel_err
);

  logic            sel_ok;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] ras_top;
  npc_src_e        nsrc;

  assign sel_ok = (int'(sel) < NSRC);
  assign pc_seq = pc + XLEN'(STEP);

  // Out-of-range select falls back to source 0
  always_comb begin
    redir_pc = src_din[XLEN-1:0];
    for (int i = 1; i < NSRC; i++) begin
      if (sel_ok && int'(sel) == i)
        redir_pc = src_din[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    nsrc = NPC_SEQ;
    if (ret && !ras_empty) nsrc = NPC_RAS;
    else if (redirect)     nsrc = NPC_REDIR;
  end

  always_comb begin
    pc_next = pc_seq;
    unique case (nsrc)
      NPC_RAS:   pc_next = ras_top;
      NPC_REDIR: pc_next = redir_pc;
      default:   pc_next = pc_seq;
    endcase
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (en && call),
    .pop   (en && ret),
    .din   (pc_seq),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= XLEN'(RESET_PC);
      ret_underflow <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      ret_underflow <= en && ret && ras_empty;
      sel_err       <= en && redirect && !sel_ok;
      if (en) pc <= pc_next;
    end
  end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter unit: the next generation of the CPU's PC counter. It holds the architectural PC and selects the next PC from sequential increment, one of `NSRC` redirect sources, or a small hardware return-address stack (RAS). It sits between the control unit, which drives `en`, `redirect`, `sel`, `call` and `ret`, and instruction memory, which consumes `pc`. Its redirect sources are the ALU, register-file and immediate paths.

## Interface
Parameters:
- `XLEN`, 32, PC width in bits
- `NSRC`, 4, number of redirect sources (≥2)
- `STEP`, 4, sequential increment
- `RESET_PC`, 0, PC value after reset
- `RAS_DEPTH`, 4, return-address stack entries (power of 2, ≥2)

Ports (SW = `$clog2(NSRC)`, AW = `$clog2(RAS_DEPTH)`):
- `clk` in 1: the single clock; all state changes on its rising edge
- `rst` in 1: reset, synchronous and active-high
- `en` in 1: advance enable; 0 = stall, all state held
- `redirect` in 1: load selected source as next PC
- `sel` in SW: redirect source index
- `src_din` in NSRC*XLEN: flattened sources; source i = bits [i*XLEN +: XLEN]
- `call` in 1: push `pc+STEP` onto RAS
- `ret` in 1: next PC = RAS top, pop
- `pc` out XLEN: current PC (registered)
- `pc_next` out XLEN: value `pc` takes at next enabled edge (combinational)
- `ras_empty` out 1: RAS count == 0
- `ras_full` out 1: RAS count == RAS_DEPTH
- `ret_underflow` out 1: registered one-cycle pulse, `ret` with empty RAS
- `sel_err` out 1: registered one-cycle pulse, `redirect` with `sel ≥ NSRC`

## Operation
- Next-PC priority when `en=1`: `ret` with non-empty RAS → RAS top; else `redirect` → `src_din[sel]`; else `pc+STEP`.
- `ret` with empty RAS: falls through to `redirect`/sequential selection; `ret_underflow` pulses; count stays 0.
- `sel ≥ NSRC` with `redirect`: source 0 is used; `sel_err` pulses.
- `call`: pushes `pc+STEP`, independent of the next-PC source (`call`+`redirect` = jump-and-link).
- `call`+`ret` together, RAS non-empty: pop target used, top slot overwritten with `pc+STEP`, count unchanged. If the RAS is empty, plain push, plus underflow pulse.
- Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH; no error.
- Arithmetic is modulo 2^XLEN; `pc+STEP` wraps silently.
- `en=0`: `pc`, RAS and count held; `call`/`ret`/`redirect` ignored; pulses deassert. `pc_next` still reflects the inputs.

## Timing
- Reset (synchronous, `rst=1` at edge): `pc=RESET_PC`, count=0, top pointer=0, `ret_underflow=0`, `sel_err=0`. RAS contents are don't-care.
- Reset dominates `en` and every control input. Reset mid-stream discards all pending RAS entries.
- Latency: a control asserted in cycle N is visible on `pc` in cycle N+1. `pc_next` is valid in cycle N.
- Back-to-back `ret`s pop successive entries at one per cycle. A `call` in cycle N is poppable by a `ret` in cycle N+1.
- Error pulses are high exactly in cycle N+1 for an offending enabled cycle N.

## Structure
- Package `pc_pkg`: defaults for `XLEN`, `STEP`, `RESET_PC`; next-source enum (`NPC_SEQ`, `NPC_REDIR`, `NPC_RAS`); a clog2-safe width function.
- Sub-module `ras_stack` (params `XLEN`, `RAS_DEPTH`): circular array, top pointer, saturating count, push/pop/replace. Outputs `top`, `empty`, `full`.
- Top level: source mux, priority select, PC register, pulse flops.

## Test plan
- Reset with RESET_PC=0x100, then 3 enabled cycles, no controls → `pc` = 0x104, 0x108, 0x10C.
- Stall: `en=0` for 2 cycles with `redirect=1` → `pc` held. `pc_next` shows `src_din[sel]`.
- Redirect `sel=2`, src2=0x2000, with `call` at pc=0x10C → `pc`=0x2000. Then `ret` → `pc`=0x110, `ras_empty=1`.
- Five calls, RAS_DEPTH=4, return addresses A1..A5 → `ras_full=1`. Four rets return A5, A4, A3, A2. A fifth `ret` → sequential PC, `ret_underflow` pulses one cycle.
- `call`+`ret` together with top=0x300 at pc=0x400 → `pc`=0x300, top=0x404, count unchanged. Also: `redirect` with `sel=3` when NSRC=3 → source 0 loaded, `sel_err` pulses.
- Wrap: `pc`=0xFFFFFFFC, sequential → 0x0. `rst` asserted mid call chain → `pc=RESET_PC`, `ras_empty=1` next cycle.
